// File: rtl/decoder_pkg.sv
// Shared types and helpers for the register-file write-enable decoder.
package decoder_pkg;

    localparam int unsigned MAX_SEL_W = 6;
    localparam int unsigned MAX_N     = 2 ** MAX_SEL_W;

    typedef enum logic {IDLE, SWEEP} sweep_state_t;

    // Widest one-hot vector; callers truncate to their own 2^SEL_W outputs.
    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_n.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with enable.
module decoder_n
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 5
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic                  en,
    output logic [(2**SEL_W)-1:0] y
);

    localparam int unsigned N = 2 ** SEL_W;

    logic [MAX_SEL_W-1:0] idx;

    always_comb begin
        idx            = '0;
        idx[SEL_W-1:0] = sel;
        y              = en ? N'(onehot(idx)) : '0;
    end

endmodule

// File: rtl/decoder_sweep.sv
// Registered one-hot write-enable decoder with a sequencer that walks every output once.
module decoder_sweep
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  en,
    input  logic                  sweep_start,
    output logic [(2**SEL_W)-1:0] d,
    output logic                  sweep_busy,
    output logic                  sweep_done
);

    localparam int unsigned N = 2 ** SEL_W;

    sweep_state_t     state_q, state_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     d_q, d_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SEL_W-1:0] dec_sel;
    logic             dec_en;

    decoder_n #(
        .SEL_W (SEL_W)
    ) u_decoder_n (
        .sel (dec_sel),
        .en  (dec_en),
        .y   (d_d)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        dec_sel = sel;
        dec_en  = en;
        unique case (state_q)
            IDLE: begin
                // A sweep request overrides any simultaneous write request.
                if (sweep_start) begin
                    dec_sel = '0;
                    dec_en  = 1'b1;
                    cnt_d   = SEL_W'(1);
                    busy_d  = 1'b1;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                dec_sel = cnt_q;
                if (cnt_q != '0) begin
                    dec_en = 1'b1;
                    cnt_d  = cnt_q + SEL_W'(1);
                    busy_d = 1'b1;
                end else begin
                    // cnt wrapped: the last output went out in the previous cycle.
                    dec_en  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign d          = d_q;
    assign sweep_busy = busy_q;
    assign sweep_done = done_q;

endmodule

// File: tb/tb_decoder_sweep.sv
// Randomised bench for decoder_sweep at SEL_W = 2, 5 and 1 against a queue-based output model.
module tb_decoder_sweep;

    typedef struct packed {
        logic [63:0] d;
        logic        busy;
        logic        done;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [1:0]  sel_a;
    logic        en_a, ss_a;
    logic [3:0]  d_a;
    logic        busy_a, done_a;

    logic [4:0]  sel_b;
    logic        en_b, ss_b;
    logic [31:0] d_b;
    logic        busy_b, done_b;

    logic [0:0]  sel_c;
    logic        en_c, ss_c;
    logic [1:0]  d_c;
    logic        busy_c, done_c;

    int          cur;
    int          npass;
    int          ntotal;
    out_t        pend[$];
    out_t        expv;
    out_t        obs;

    decoder_sweep #(.SEL_W(2)) dut_a (
        .clk (clk), .reset (reset), .sel (sel_a), .en (en_a), .sweep_start (ss_a),
        .d (d_a), .sweep_busy (busy_a), .sweep_done (done_a)
    );
    decoder_sweep #(.SEL_W(5)) dut_b (
        .clk (clk), .reset (reset), .sel (sel_b), .en (en_b), .sweep_start (ss_b),
        .d (d_b), .sweep_busy (busy_b), .sweep_done (done_b)
    );
    decoder_sweep #(.SEL_W(1)) dut_c (
        .clk (clk), .reset (reset), .sel (sel_c), .en (en_c), .sweep_start (ss_c),
        .d (d_c), .sweep_busy (busy_c), .sweep_done (done_c)
    );

    always #5 clk = ~clk;

    always_comb begin
        obs = '0;
        case (cur)
            0:       obs = '{d: 64'(d_a), busy: busy_a, done: done_a};
            1:       obs = '{d: 64'(d_b), busy: busy_b, done: done_b};
            default: obs = '{d: 64'(d_c), busy: busy_c, done: done_c};
        endcase
    end

    function automatic int nout(input int u);
        return (u == 0) ? 4 : (u == 1) ? 32 : 2;
    endfunction

    // Drive one cycle of stimulus to the unit under test and advance the model.
    task automatic tick(input bit ss, input bit e, input int unsigned s);
        ss_a = (cur == 0) && ss;  en_a = (cur == 0) && e;  sel_a = 2'(s);
        ss_b = (cur == 1) && ss;  en_b = (cur == 1) && e;  sel_b = 5'(s);
        ss_c = (cur == 2) && ss;  en_c = (cur == 2) && e;  sel_c = 1'(s);
        @(posedge clk);
        if (pend.size() == 0) begin
            if (ss) begin
                for (int i = 0; i < nout(cur); i++)
                    pend.push_back('{d: 64'(1) << i, busy: 1'b1, done: 1'b0});
                pend.push_back('{d: 64'd0, busy: 1'b0, done: 1'b1});
            end else if (e) begin
                pend.push_back('{d: 64'(1) << s, busy: 1'b0, done: 1'b0});
            end else begin
                pend.push_back('{d: 64'd0, busy: 1'b0, done: 1'b0});
            end
        end
        expv = pend.pop_front();
        #2;
    endtask

    task automatic drain_and_select(input int u);
        while (pend.size() > 0) tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        cur = u;
    endtask

    task automatic test_reset();
        cur = 0;
        #12;
        @(negedge clk);
        reset = 1'b0;
        tick(1'b0, 1'b1, $urandom_range(3));
        ntotal++;
        if (obs !== expv) $display("FAIL reset_pre d=%h busy=%b done=%b want d=%h busy=%b done=%b",
                                   obs.d, obs.busy, obs.done, expv.d, expv.busy, expv.done);
        else npass++;
        #1 reset = 1'b1;
        #1;
        pend.delete();
        expv = '0;
        ntotal++;
        if (obs !== expv) $display("FAIL reset_async d=%h busy=%b done=%b want all zero",
                                   obs.d, obs.busy, obs.done);
        else npass++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 0);
            ntotal++;
            if (obs !== expv) $display("FAIL reset_idle%0d d=%h busy=%b done=%b want zero",
                                       i, obs.d, obs.busy, obs.done);
            else npass++;
        end
    endtask

    task automatic test_decode();
        int unsigned s;
        cur = 0;
        for (int i = 0; i < 25; i++) begin
            s = (i < 4) ? i : $urandom_range(3);
            if (i == 4) tick(1'b0, 1'b0, 2);
            else        tick(1'b0, (i < 4) ? 1'b1 : 1'($urandom_range(1)), s);
            ntotal++;
            if (obs !== expv) $display("FAIL decode%0d d=%h busy=%b done=%b want d=%h busy=%b done=%b",
                                       i, obs.d, obs.busy, obs.done, expv.d, expv.busy, expv.done);
            else npass++;
        end
    endtask

    task automatic test_sweep();
        drain_and_select(0);
        for (int i = 0; i < 6; i++) begin
            tick(i == 0, 1'b0, 0);
            ntotal++;
            if (obs !== expv) $display("FAIL sweep%0d d=%h busy=%b done=%b want d=%h busy=%b done=%b",
                                       i, obs.d, obs.busy, obs.done, expv.d, expv.busy, expv.done);
            else npass++;
        end
    endtask

    task automatic test_conflict();
        drain_and_select(0);
        tick(1'b1, 1'b1, 3);
        ntotal++;
        if (obs.d !== 64'h1 || obs.busy !== 1'b1)
            $display("FAIL conflict_start d=%h busy=%b want d=1 busy=1", obs.d, obs.busy);
        else npass++;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) tick(1'b1, 1'b1, 1);
            else       tick(1'b0, 1'b0, 0);
            ntotal++;
            if (obs !== expv) $display("FAIL conflict%0d d=%h busy=%b done=%b want d=%h busy=%b done=%b",
                                       i, obs.d, obs.busy, obs.done, expv.d, expv.busy, expv.done);
            else npass++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        drain_and_select(1);
        for (int i = 0; i <= 10; i++) begin
            tick(i == 0, 1'b0, 0);
            ntotal++;
            if (obs !== expv) $display("FAIL midsweep%0d d=%h busy=%b done=%b want d=%h busy=%b done=%b",
                                       i, obs.d, obs.busy, obs.done, expv.d, expv.busy, expv.done);
            else npass++;
        end
        #1 reset = 1'b1;
        #1;
        pend.delete();
        expv = '0;
        ntotal++;
        if (obs !== expv) $display("FAIL midsweep_reset d=%h busy=%b done=%b want zero",
                                   obs.d, obs.busy, obs.done);
        else npass++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, i == 39, 31);
            ntotal++;
            if (obs !== expv) $display("FAIL midsweep_after%0d d=%h busy=%b done=%b want d=%h busy=%b done=%b",
                                       i, obs.d, obs.busy, obs.done, expv.d, expv.busy, expv.done);
            else npass++;
        end
        ntotal++;
        if (d_b !== 32'h8000_0000) $display("FAIL sel31 d=%h want 80000000", d_b);
        else npass++;
    endtask

    task automatic test_back_to_back();
        bit          ss_tab[7]   = '{1, 0, 0, 1, 0, 0, 0};
        logic [1:0]  d_tab[7]    = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
        logic        done_tab[7] = '{0, 0, 1, 0, 0, 1, 0};
        drain_and_select(2);
        for (int i = 0; i < 7; i++) begin
            tick(ss_tab[i], 1'b0, 0);
            ntotal++;
            if (obs !== expv || d_c !== d_tab[i] || done_c !== done_tab[i] || $countones(d_c) > 1)
                $display("FAIL b2b%0d d=%b busy=%b done=%b want d=%b done=%b",
                         i, d_c, busy_c, done_c, d_tab[i], done_tab[i]);
            else npass++;
        end
    endtask

    task automatic test_random();
        for (int u = 0; u < 3; u++) begin
            drain_and_select(u);
            for (int i = 0; i < 150; i++) begin
                tick($urandom_range(11) == 0, 1'($urandom_range(1)), $urandom_range(nout(u) - 1));
                ntotal++;
                if (obs !== expv || $countones(obs.d) > 1)
                    $display("FAIL rand_u%0d_%0d d=%h busy=%b done=%b want d=%h busy=%b done=%b",
                             u, i, obs.d, obs.busy, obs.done, expv.d, expv.busy, expv.done);
                else npass++;
            end
        end
    endtask

    initial begin
        npass  = 0;
        ntotal = 0;
        cur    = 0;
        expv   = '0;
        {sel_a, en_a, ss_a} = '0;
        {sel_b, en_b, ss_b} = '0;
        {sel_c, en_c, ss_c} = '0;
        test_reset();
        test_decode();
        test_sweep();
        test_conflict();
        test_reset_mid_sweep();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
